sik_encoder: RTL

//   Instruction encoder/writer for the SIK stack ISA: converts (opcode, 16-bit immediate) requests

---
 rtl/sik_encoder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sik_encoder.sv
// sik_encoder: turns (opcode, immediate) requests into SIK instruction words
// and streams them, with a `pre` prefix word when the immediate needs one,
// to the instruction-memory write port at consecutive addresses.
//
// Handshake rules for both ports: a transfer happens on a rising edge where
// valid and ready are both high. The request side may drop or change its
// fields at any time. The output side holds out_valid, out_data and out_addr
// stable until the transfer. req_ready depends combinationally on out_ready,
// so a new request can be taken in the same cycle as the last word drains.
module sik_encoder #(
   parameter logic [15:0] BASE_ADDR  = 16'h0000,
   parameter bit          ALWAYS_PRE = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_ext,
   input  logic [3:0]  req_op,
   input  logic [15:0] req_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_addr,
   output logic [15:0] out_data,
   output logic        err,
   output logic        wrapped,
   output logic [15:0] word_count
);

   // IDLE: nothing on the output; PRE: prefix word shown; MAIN: main/extended word shown
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      MAIN = 2'd2
   } state_t;

   state_t state;
   state_t state_next;
   state_t load_state;

   // Holding register: the request as captured at accept time
   logic        hold_ext;
   logic [3:0]  hold_op;
   logic [15:0] hold_imm;

   logic accept;
   logic out_fire;
   logic req_legal;
   logic req_pre;
   logic imm_fits;

   assign out_fire  = out_valid & out_ready;
   assign req_ready = (state == IDLE) | ((state == MAIN) & out_ready);
   assign accept    = req_valid & req_ready;

   // The immediate fits the 12-bit field when bits 15..11 are all copies of the sign
   assign imm_fits = (req_imm[15:11] == 5'b00000) | (req_imm[15:11] == 5'b11111);

   // Decode legality and prefix need of the request currently on the inputs
   always_comb begin
      req_legal  = 1'b0;
      req_pre    = 1'b0;
      load_state = IDLE;
      if (req_ext) begin
         req_legal = (req_op >= 4'd1) && (req_op <= 4'd12);
      end else begin
         req_legal = (req_op >= 4'd1) && (req_op <= 4'd8);
         req_pre   = ALWAYS_PRE || !imm_fits;
      end
      if (req_legal) begin
         load_state = req_pre ? PRE : MAIN;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and output word selection
   always_comb begin
      state_next = state;
      out_valid  = 1'b0;
      out_data   = 16'h0000;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = load_state;
            end
         end
         PRE: begin
            out_valid = 1'b1;
            out_data  = {4'b1111, 8'h00, hold_imm[15:12]};
            if (out_fire) begin
               state_next = MAIN;
            end
         end
         MAIN: begin
            out_valid = 1'b1;
            if (hold_ext) begin
               out_data = {4'b0000, 8'h00, hold_op};
            end else begin
               out_data = {hold_op, hold_imm[11:0]};
            end
            // accept here implies out_ready, so the word drains this cycle too
            if (out_fire) begin
               state_next = accept ? load_state : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Capture legal requests; illegal ones only raise err for a cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_ext <= 1'b0;
         hold_op  <= 4'h0;
         hold_imm <= 16'h0000;
         err      <= 1'b0;
      end else begin
         err <= accept & ~req_legal;
         if (accept & req_legal) begin
            hold_ext <= req_ext;
            hold_op  <= req_op;
            hold_imm <= req_imm;
         end
      end
   end

   // Write address, wrap flag and emitted-word counter advance per output transfer
   always_ff @(posedge clk) begin
      if (reset) begin
         out_addr   <= BASE_ADDR;
         wrapped    <= 1'b0;
         word_count <= 16'h0000;
      end else if (out_fire) begin
         out_addr   <= out_addr + 16'd1;
         word_count <= word_count + 16'd1;
         if (out_addr == 16'hFFFF) begin
            wrapped <= 1'b1;
         end
      end
   end

endmodule
